sdio_data_tx: RTL and testbench
===============================

# sdio_data_tx

Host-side SDIO 4-bit write-data transmitter; counterpart to the receive-side data handler on the same DAT[3:0] pins. It accepts one block of bytes over a valid/ready stream and serialises it as start bit, nibbles, per-lane CRC16 and end bit. It then releases the bus and collects the card's CRC status token and busy phase. It sits between the write buffer and the DAT pad logic; the pad tri-state is driven from `sd_dat_oe`.

## Interface

Reset is synchronous and active-high; the block has one clock, `sd_clk`.

Parameters:
- `STAT_TIMEOUT`, default 8: maximum `sd_clk` cycles from bus release to the status start bit.
- `BUSY_TIMEOUT`, default 65535: maximum busy cycles; counter is 16 bits.

Ports:
- `sd_clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request; ignored while `busy` is high.
- `blk_len` in 10: block length in bytes; 1..511, 0 means 512; latched on `start`.
- `in_data` in 8: write byte.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: byte accepted when `in_valid && in_ready`.
- `sd_dat_in` in 4: sampled pin values (DAT0 used for status/busy).
- `sd_dat_out` out 4: registered pin drive.
- `sd_dat_oe` out 1: registered output enable.
- `busy` out 1: high from `start` accept until `done`.
- `done` out 1: one-cycle completion pulse.
- `status` out 3: received status token bits.
- `status_err` out 1: token not 3'b010 or bad end bit.
- `timeout_err` out 1: status or busy timeout.
- `underrun_err` out 1: `in_valid` low when a byte was due.

## Operation

- **Reset values:** `sd_dat_out`=4'hF, `sd_dat_oe`=0, `in_ready`=0, `busy`=0, `done`=0, `status`=0, all errors 0; state IDLE. Reset mid-transfer aborts at once: pins are released on the next edge and no `done` is issued.
- **States:** IDLE → PRE → START → DATA → CRC → END → STAT_WAIT → STAT → BUSY → DONE → IDLE.
- **PRE:** drive 4'hF with `oe`=1 for one cycle.
- **START:** drive 4'h0 for one cycle. Clear the four lane CRCs and the byte counter.
- **DATA:** two cycles per byte, high nibble first.
  - `in_ready`=1 only in the high-nibble cycle.
  - On that edge, `sd_dat_out` <= `in_data[7:4]` and the hold register <= `in_data[3:0]`. On the next edge, `sd_dat_out` <= hold.
  - `sd_dat_out[i]` maps to DAT[i]. Each lane CRC updates with the bit driven on it.
- **Underrun:** `in_valid`=0 in a high-nibble cycle sets `underrun_err`, sets `oe`=0 and goes to DONE.
- **CRC:** 16 cycles; lane i drives `crc[i][15]` first, MSB→LSB.
- **CRC16 per lane:** poly 0x1021, init 0. Update: fb = bit ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
- **END:** drive 4'hF for one cycle, then `oe`=0 on the next edge.
- **STAT_WAIT:** wait for DAT0=0.
  - Counter counts cycles since release.
  - Reaching `STAT_TIMEOUT` sets `timeout_err` and goes to DONE.
- **STAT:** shift three DAT0 samples MSB first into `status`, then sample the end bit.
  - `status_err`=1 if `status` != 3'b010 or end bit = 0.
  - Proceed to BUSY regardless.
- **BUSY:** stay while DAT0=0. First DAT0=1 → DONE.
  - Counter reaching `BUSY_TIMEOUT` sets `timeout_err` → DONE.
- **DONE:** `done`=1 for one cycle; `busy` falls on the same edge that returns to IDLE.
- **Error flags:** hold until the next accepted `start`, which clears them.

## Timing

- `start` accepted at edge 0. Pin values per cycle:
  - cycle 1: PRE, F.
  - cycle 2: start bit 0.
  - cycles 3..2+2N: data nibbles.
  - next 16 cycles: CRC.
  - next 1 cycle: end bit F.
  - following cycle: `oe`=0.
- Total driven cycles: 2N+19. With N=512, driven cycles = 1043.
- First `in_ready` is in cycle 2, for the byte driven in cycle 3.
- `sd_dat_in` is sampled on every `sd_clk` rising edge with no synchroniser; pad-level alignment is outside this block.
- The status start bit may arrive on the first cycle after release.
- `done` follows the busy release by exactly 1 cycle.

## Structure

- Shared package `sdio_pkg`:
  - CRC16 polynomial constant 16'h1021.
  - Status token codes: ACCEPTED 3'b010, CRC_ERR 3'b101, WRITE_ERR 3'b110.
  - State encoding localparams.
- Sub-module `sdio_crc16_lane`: serial CRC16 with `clr`, `en`, `bit_in`, `crc` ports; instantiated four times.

## Test plan

- **All-zero block:** `blk_len`=4, data 8'h00 ×4, card returns token 010 with no busy.
  - Pins show F, 0, eight 0-nibbles, sixteen 0 bits per lane, F.
  - `status`=3'b010, no errors, `done` one cycle after DAT0 returns high.
- **Nibble order:** `blk_len`=1, byte 8'hA5.
  - Cycle 3 = 4'hA, cycle 4 = 4'h5.
  - Lane CRCs match the software model; `oe` drops at cycle 22.
- **Full block and busy:** `blk_len`=0 (512 bytes), busy held 1000 cycles.
  - 1043 driven cycles, `busy` high throughout, `done` asserted once.
- **CRC error token:** card returns 101.
  - `status`=3'b101, `status_err`=1, BUSY still tracked, `done` asserted.
- **Timeouts:** no start bit for 8 cycles → `timeout_err`=1. Separately, busy held beyond `BUSY_TIMEOUT`=16 (parameter override) → `timeout_err`=1.
- **Underrun and reset:** drop `in_valid` at byte 3 → `underrun_err`, `oe`=0 next edge. Separately, `rst` asserted mid-DATA → all outputs at reset values next cycle and no `done`.

Source files
------------

// File: rtl/sdio_pkg.sv
// Shared constants, token codes and state encoding for the SDIO 4-bit write-data path.
package sdio_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;

  localparam logic [2:0]  TOK_ACCEPTED  = 3'b010;
  localparam logic [2:0]  TOK_CRC_ERR   = 3'b101;
  localparam logic [2:0]  TOK_WRITE_ERR = 3'b110;

  localparam int          STATE_W       = 4;
  localparam logic [STATE_W-1:0] ST_IDLE      = 4'd0;
  localparam logic [STATE_W-1:0] ST_PRE       = 4'd1;
  localparam logic [STATE_W-1:0] ST_START     = 4'd2;
  localparam logic [STATE_W-1:0] ST_DATA      = 4'd3;
  localparam logic [STATE_W-1:0] ST_CRC       = 4'd4;
  localparam logic [STATE_W-1:0] ST_END       = 4'd5;
  localparam logic [STATE_W-1:0] ST_STAT_WAIT = 4'd6;
  localparam logic [STATE_W-1:0] ST_STAT      = 4'd7;
  localparam logic [STATE_W-1:0] ST_BUSY      = 4'd8;
  localparam logic [STATE_W-1:0] ST_DONE      = 4'd9;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = ST_IDLE,
    S_PRE       = ST_PRE,
    S_START     = ST_START,
    S_DATA      = ST_DATA,
    S_CRC       = ST_CRC,
    S_END       = ST_END,
    S_STAT_WAIT = ST_STAT_WAIT,
    S_STAT      = ST_STAT,
    S_BUSY      = ST_BUSY,
    S_DONE      = ST_DONE
  } tx_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdio_crc16_lane.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0) for one DAT lane; updates one bit per enabled cycle.
// Feeding bit_in = crc[15] turns the register into a plain left shift for read-out.
module sdio_crc16_lane
  import sdio_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc16_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdio_data_tx.sv
// Host SDIO 4-bit write transmitter: start bit, nibbles, lane CRC16, end bit, then status token and busy.
// Pins are registered from the next-state decision; a missing byte aborts the block (underrun) instead of stalling.
module sdio_data_tx
  import sdio_pkg::*;
#(
  parameter int STAT_TIMEOUT = 8,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic       sd_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] blk_len,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] sd_dat_in,
  output logic [3:0] sd_dat_out,
  output logic       sd_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [2:0] status,
  output logic       status_err,
  output logic       timeout_err,
  output logic       underrun_err
);

  localparam logic [15:0] STAT_LIM = 16'(STAT_TIMEOUT - 1);
  localparam logic [15:0] BUSY_LIM = 16'(BUSY_TIMEOUT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  rem_q, rem_d;
  logic        lo_q, lo_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  dat_q, dat_d;
  logic        oe_q, oe_d;
  logic [2:0]  status_q, status_d;
  logic        serr_q, serr_d, terr_q, terr_d, uerr_q, uerr_d;
  logic        crc_clr, crc_en;
  logic [3:0]  crc_bits, crc_msb, unused_crc_lo;
  logic        dat0, unused_dat_hi;

  assign dat0          = sd_dat_in[0];
  assign unused_dat_hi = ^sd_dat_in[3:1];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [15:0] crc;
    sdio_crc16_lane u_lane (
      .clk(sd_clk), .rst(rst), .clr(crc_clr), .en(crc_en), .bit_in(crc_bits[l]), .crc(crc)
    );
    assign crc_msb[l]       = crc[15];
    assign unused_crc_lo[l] = ^crc[14:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    lo_d     = lo_q;
    hold_d   = hold_q;
    dat_d    = dat_q;
    oe_d     = oe_q;
    status_d = status_q;
    serr_d   = serr_q;
    terr_d   = terr_q;
    uerr_d   = uerr_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    crc_bits = 4'h0;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d  = S_PRE;
        dat_d    = 4'hF;
        oe_d     = 1'b1;
        rem_d    = (blk_len == 10'd0) ? 10'd512 : blk_len;
        status_d = 3'b000;
        serr_d   = 1'b0;
        terr_d   = 1'b0;
        uerr_d   = 1'b0;
      end
      S_PRE: begin
        state_d = S_START;
        dat_d   = 4'h0;
        crc_clr = 1'b1;
      end
      // A byte is taken while its predecessor's low nibble (or the start bit) is on the pins.
      S_START, S_DATA: begin
        if (state_q == S_DATA && !lo_q) begin
          dat_d    = hold_q;
          lo_d     = 1'b1;
          crc_en   = 1'b1;
          crc_bits = hold_q;
        end else if (rem_q != 10'd0) begin
          in_ready = 1'b1;
          if (in_valid) begin
            state_d  = S_DATA;
            dat_d    = in_data[7:4];
            hold_d   = in_data[3:0];
            rem_d    = rem_q - 10'd1;
            lo_d     = 1'b0;
            crc_en   = 1'b1;
            crc_bits = in_data[7:4];
          end else begin
            state_d = S_DONE;
            dat_d   = 4'hF;
            oe_d    = 1'b0;
            uerr_d  = 1'b1;
          end
        end else begin
          state_d  = S_CRC;
          dat_d    = crc_msb;
          crc_en   = 1'b1;
          crc_bits = crc_msb;
          cnt_d    = 16'd0;
        end
      end
      S_CRC: begin
        if (cnt_q == 16'd15) begin
          state_d = S_END;
          dat_d   = 4'hF;
        end else begin
          dat_d    = crc_msb;
          crc_en   = 1'b1;
          crc_bits = crc_msb;
          cnt_d    = cnt_q + 16'd1;
        end
      end
      S_END: begin
        state_d = S_STAT_WAIT;
        oe_d    = 1'b0;
        cnt_d   = 16'd0;
      end
      S_STAT_WAIT: begin
        if (!dat0) begin
          state_d = S_STAT;
          cnt_d   = 16'd0;
        end else if (cnt_q == STAT_LIM) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STAT: begin
        if (cnt_q < 16'd3) begin
          status_d = {status_q[1:0], dat0};
          cnt_d    = cnt_q + 16'd1;
        end else begin
          serr_d  = (status_q != TOK_ACCEPTED) || !dat0;
          state_d = S_BUSY;
          cnt_d   = 16'd0;
        end
      end
      S_BUSY: begin
        if (dat0) begin
          state_d = S_DONE;
        end else if (cnt_q == BUSY_LIM) begin
          state_d = S_DONE;
          terr_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sd_clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      lo_q     <= 1'b0;
      hold_q   <= '0;
      dat_q    <= 4'hF;
      oe_q     <= 1'b0;
      status_q <= '0;
      serr_q   <= 1'b0;
      terr_q   <= 1'b0;
      uerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      lo_q     <= lo_d;
      hold_q   <= hold_d;
      dat_q    <= dat_d;
      oe_q     <= oe_d;
      status_q <= status_d;
      serr_q   <= serr_d;
      terr_q   <= terr_d;
      uerr_q   <= uerr_d;
    end
  end

  assign sd_dat_out   = dat_q;
  assign sd_dat_oe    = oe_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign status       = status_q;
  assign status_err   = serr_q;
  assign timeout_err  = terr_q;
  assign underrun_err = uerr_q;

endmodule

// File: tb/tb_sdio_data_tx.sv
// Bench for sdio_data_tx: pin-level scoreboard of driven nibbles plus a scripted card for status and busy.
module tb_sdio_data_tx;

  logic       sd_clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, sel = 1'b0;
  logic [9:0] blk_len = '0;
  logic [7:0] in_data = '0;
  logic [3:0] sd_dat_in = 4'hF;

  logic       a_rdy, a_oe, a_busy, a_done, a_serr, a_terr, a_uerr;
  logic       b_rdy, b_oe, b_busy, b_done, b_serr, b_terr, b_uerr;
  logic [3:0] a_dat, b_dat;
  logic [2:0] a_stat, b_stat;

  logic       o_rdy, o_oe, o_busy, o_done, o_serr, o_terr, o_uerr;
  logic [3:0] o_dat;
  logic [2:0] o_stat;

  assign o_rdy  = sel ? b_rdy  : a_rdy;
  assign o_oe   = sel ? b_oe   : a_oe;
  assign o_busy = sel ? b_busy : a_busy;
  assign o_done = sel ? b_done : a_done;
  assign o_serr = sel ? b_serr : a_serr;
  assign o_terr = sel ? b_terr : a_terr;
  assign o_uerr = sel ? b_uerr : a_uerr;
  assign o_dat  = sel ? b_dat  : a_dat;
  assign o_stat = sel ? b_stat : a_stat;

  always #5 sd_clk = ~sd_clk;

  sdio_data_tx dut_a (
    .sd_clk(sd_clk), .rst(rst), .start(start), .blk_len(blk_len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(a_rdy), .sd_dat_in(sd_dat_in), .sd_dat_out(a_dat),
    .sd_dat_oe(a_oe), .busy(a_busy), .done(a_done), .status(a_stat), .status_err(a_serr),
    .timeout_err(a_terr), .underrun_err(a_uerr)
  );

  sdio_data_tx #(.BUSY_TIMEOUT(16)) dut_b (
    .sd_clk(sd_clk), .rst(rst), .start(start), .blk_len(blk_len), .in_data(in_data),
    .in_valid(in_valid), .in_ready(b_rdy), .sd_dat_in(sd_dat_in), .sd_dat_out(b_dat),
    .sd_dat_oe(b_oe), .busy(b_busy), .done(b_done), .status(b_stat), .status_err(b_serr),
    .timeout_err(b_terr), .underrun_err(b_uerr)
  );

  int         n_vec = 0, n_err = 0;
  logic [3:0] exp_q [$];
  int         r_driven, r_rel, r_done_cnt, r_done_cyc, r_busy_gap, r_first_rdy;
  logic       r_busy_after, r_serr, r_terr, r_uerr;
  logic [2:0] r_stat;
  logic [3:0] pin_at [64];

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Card DAT0 for the t-th cycle after the host releases the bus; sd < 0 means the card never answers.
  function automatic logic card_bit(input int t, input int sd, input logic [2:0] tok,
                                    input logic endb, input int bc);
    logic [2:0] s;
    if (sd < 0 || t < sd) return 1'b1;
    if (t == sd) return 1'b0;
    if (t <= sd + 3) begin
      s = tok << (t - sd - 1);
      return s[2];
    end
    if (t == sd + 4) return endb;
    if (t <= sd + 4 + bc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_xfer(input logic use_b, input int len, input int kind, input logic [2:0] tok,
                          input logic endb, input int sd, input int bc, input int ur_at);
    logic [7:0]  data [$];
    logic [15:0] mc [4];
    logic [15:0] tmp;
    logic [3:0]  hi, lo, nib, exp_pin;
    int          nb, idx, cyc, limit;
    start = 1'b0; in_valid = 1'b0; sd_dat_in = 4'hF;
    for (int w = 0; w < 200 && (a_busy || b_busy); w++) @(negedge sd_clk);
    n_vec++;
    if (a_busy || b_busy) begin
      n_err++;
      $display("FAIL idle_before_start busy a=%b b=%b required 0", a_busy, b_busy);
    end
    sel = use_b;
    exp_q.delete();
    for (int i = 0; i < len; i++)
      data.push_back(kind == 0 ? 8'h00 : kind == 1 ? 8'hA5 : 8'($urandom_range(0, 255)));
    for (int l = 0; l < 4; l++) mc[l] = 16'h0000;
    exp_q.push_back(4'hF);
    exp_q.push_back(4'h0);
    nb = (ur_at >= 0) ? ur_at : len;
    for (int i = 0; i < nb; i++) begin
      hi = data[i][7:4];
      lo = data[i][3:0];
      exp_q.push_back(hi);
      for (int l = 0; l < 4; l++) mc[l] = crc_upd(mc[l], hi[l]);
      exp_q.push_back(lo);
      for (int l = 0; l < 4; l++) mc[l] = crc_upd(mc[l], lo[l]);
    end
    if (ur_at < 0) begin
      for (int k = 0; k < 16; k++) begin
        for (int l = 0; l < 4; l++) begin
          tmp = mc[l] << k;
          nib[l] = tmp[15];
        end
        exp_q.push_back(nib);
      end
      exp_q.push_back(4'hF);
    end
    r_driven = 0; r_rel = -1; r_done_cnt = 0; r_done_cyc = -1; r_busy_gap = 0;
    r_first_rdy = -1; r_busy_after = 1'b1;
    idx = 0;
    limit = 2 * len + bc + 100;
    @(negedge sd_clk);
    start = 1'b1;
    blk_len = 10'(len % 512);
    in_valid = (ur_at != 0);
    @(posedge sd_clk);
    cyc = 1;
    forever begin
      @(negedge sd_clk);
      start = 1'b0;
      if (cyc < 64) pin_at[cyc] = o_dat;
      if (o_oe) begin
        r_driven++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pin_extra cyc=%0d got=%h required no drive", cyc, o_dat);
        end else begin
          exp_pin = exp_q.pop_front();
          if (o_dat !== exp_pin) begin
            n_err++;
            $display("FAIL pin cyc=%0d got=%h required %h", cyc, o_dat, exp_pin);
          end
        end
      end else if (r_rel < 0) begin
        r_rel = cyc;
      end
      if (!o_busy && r_done_cnt == 0) r_busy_gap++;
      if (r_done_cnt > 0 && cyc == r_done_cyc + 1) r_busy_after = o_busy;
      if (o_done) begin
        r_done_cnt++;
        if (r_done_cnt == 1) begin
          r_done_cyc = cyc;
          r_stat = o_stat; r_serr = o_serr; r_terr = o_terr; r_uerr = o_uerr;
        end
      end
      if (r_rel >= 0) sd_dat_in = {3'b111, card_bit(cyc - r_rel, sd, tok, endb, bc)};
      if (o_rdy) begin
        if (r_first_rdy < 0) r_first_rdy = cyc;
        if (idx == ur_at || idx >= len) begin
          in_valid = 1'b0;
        end else begin
          in_valid = 1'b1;
          in_data = data[idx];
        end
        idx++;
      end
      if (r_done_cnt > 0 && cyc >= r_done_cyc + 2) break;
      if (cyc >= limit) begin
        n_vec++; n_err++;
        $display("FAIL done_timeout no done within %0d cycles", limit);
        break;
      end
      @(posedge sd_clk);
      cyc++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pin_missing got %0d nibbles undriven required 0", exp_q.size());
    end
    in_valid = 1'b0;
    sd_dat_in = 4'hF;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge sd_clk);
    n_vec++;
    if ({a_dat, a_oe, a_rdy, a_busy, a_done} !== 8'b1111_0000) begin
      n_err++;
      $display("FAIL reset_ctl got=%b required 11110000", {a_dat, a_oe, a_rdy, a_busy, a_done});
    end
    n_vec++;
    if ({a_stat, a_serr, a_terr, a_uerr} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b required 000000", {a_stat, a_serr, a_terr, a_uerr});
    end
    rst = 1'b0;
  endtask

  task automatic test_all_zero();
    run_xfer(1'b0, 4, 0, 3'b010, 1'b1, 2, 0, -1);
    n_vec++;
    if (r_driven != 27) begin n_err++; $display("FAIL zero_driven got=%0d required 27", r_driven); end
    n_vec++;
    if (r_rel != 28) begin n_err++; $display("FAIL zero_release got=%0d required 28", r_rel); end
    n_vec++;
    if (r_done_cyc != 36) begin n_err++; $display("FAIL zero_done_cyc got=%0d required 36", r_done_cyc); end
    n_vec++;
    if ({r_stat, r_serr, r_terr, r_uerr} !== 6'b010_000) begin
      n_err++;
      $display("FAIL zero_status got=%b required 010000", {r_stat, r_serr, r_terr, r_uerr});
    end
  endtask

  task automatic test_nibble_order();
    run_xfer(1'b0, 1, 1, 3'b010, 1'b1, 0, 3, -1);
    n_vec++;
    if ({pin_at[3], pin_at[4]} !== 8'hA5) begin
      n_err++;
      $display("FAIL nibble_order got=%h%h required a5", pin_at[3], pin_at[4]);
    end
    n_vec++;
    if (r_first_rdy != 2) begin n_err++; $display("FAIL first_ready got=%0d required 2", r_first_rdy); end
    n_vec++;
    if (r_rel != 22) begin n_err++; $display("FAIL oe_drop got=%0d required 22", r_rel); end
    n_vec++;
    if (r_done_cyc != 31) begin n_err++; $display("FAIL nib_done_cyc got=%0d required 31", r_done_cyc); end
  endtask

  task automatic test_status_token();
    run_xfer(1'b0, 2, 2, 3'b101, 1'b1, 1, 5, -1);
    n_vec++;
    if ({r_stat, r_serr, r_terr} !== 5'b101_10) begin
      n_err++;
      $display("FAIL crc_token got=%b required 10110", {r_stat, r_serr, r_terr});
    end
    n_vec++;
    if (r_done_cyc != 36 || r_done_cnt != 1) begin
      n_err++;
      $display("FAIL crc_token_done cyc=%0d cnt=%0d required 36 1", r_done_cyc, r_done_cnt);
    end
    run_xfer(1'b0, 1, 2, 3'b010, 1'b0, 0, 0, -1);
    n_vec++;
    if ({r_stat, r_serr} !== 4'b010_1) begin
      n_err++;
      $display("FAIL bad_end_bit got=%b required 0101", {r_stat, r_serr});
    end
  endtask

  task automatic test_timeouts();
    run_xfer(1'b0, 3, 2, 3'b010, 1'b1, -1, 0, -1);
    n_vec++;
    if ({r_stat, r_serr, r_terr} !== 5'b000_01 || r_done_cyc != 34) begin
      n_err++;
      $display("FAIL stat_timeout flags=%b cyc=%0d required 00001 34", {r_stat, r_serr, r_terr}, r_done_cyc);
    end
    run_xfer(1'b1, 2, 1, 3'b010, 1'b1, 1, 20, -1);
    n_vec++;
    if ({r_stat, r_serr, r_terr} !== 5'b010_01 || r_done_cyc != 46) begin
      n_err++;
      $display("FAIL busy_timeout flags=%b cyc=%0d required 01001 46", {r_stat, r_serr, r_terr}, r_done_cyc);
    end
  endtask

  task automatic test_underrun();
    run_xfer(1'b0, 6, 2, 3'b010, 1'b1, 0, 0, 3);
    n_vec++;
    if (r_driven != 8 || r_rel != 9) begin
      n_err++;
      $display("FAIL underrun_oe driven=%0d rel=%0d required 8 9", r_driven, r_rel);
    end
    n_vec++;
    if ({r_uerr, r_terr} !== 2'b10 || r_done_cyc != 9) begin
      n_err++;
      $display("FAIL underrun_flag got=%b cyc=%0d required 10 9", {r_uerr, r_terr}, r_done_cyc);
    end
  endtask

  task automatic test_full_block();
    run_xfer(1'b0, 512, 2, 3'b010, 1'b1, 0, 1000, -1);
    n_vec++;
    if (r_driven != 1043) begin n_err++; $display("FAIL full_driven got=%0d required 1043", r_driven); end
    n_vec++;
    if (r_busy_gap != 0 || r_busy_after !== 1'b0) begin
      n_err++;
      $display("FAIL full_busy gaps=%0d after=%b required 0 0", r_busy_gap, r_busy_after);
    end
    n_vec++;
    if (r_done_cnt != 1 || r_done_cyc != 2050) begin
      n_err++;
      $display("FAIL full_done cnt=%0d cyc=%0d required 1 2050", r_done_cnt, r_done_cyc);
    end
    n_vec++;
    if ({r_serr, r_terr, r_uerr} !== 3'b000) begin
      n_err++;
      $display("FAIL full_flags got=%b required 000", {r_serr, r_terr, r_uerr});
    end
  endtask

  task automatic test_reset_mid();
    int dn;
    sel = 1'b0;
    for (int w = 0; w < 200 && (a_busy || b_busy); w++) @(negedge sd_clk);
    @(negedge sd_clk);
    start = 1'b1; blk_len = 10'd8; in_valid = 1'b1; in_data = 8'h3C;
    @(negedge sd_clk);
    start = 1'b0;
    repeat (4) @(negedge sd_clk);
    n_vec++;
    if (a_oe !== 1'b1) begin n_err++; $display("FAIL mid_active oe got=%b required 1", a_oe); end
    rst = 1'b1;
    @(negedge sd_clk);
    n_vec++;
    if ({a_dat, a_oe, a_rdy, a_busy, a_done} !== 8'b1111_0000) begin
      n_err++;
      $display("FAIL mid_reset_ctl got=%b required 11110000", {a_dat, a_oe, a_rdy, a_busy, a_done});
    end
    n_vec++;
    if ({a_stat, a_serr, a_terr, a_uerr} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_reset_flags got=%b required 000000", {a_stat, a_serr, a_terr, a_uerr});
    end
    rst = 1'b0;
    dn = 0;
    repeat (40) begin
      @(negedge sd_clk);
      if (a_done || a_oe) dn++;
    end
    n_vec++;
    if (dn != 0) begin n_err++; $display("FAIL mid_reset_done got=%0d cycles required 0", dn); end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_nibble_order();
    test_status_token();
    test_timeouts();
    test_underrun();
    test_full_block();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
